qpu_exu_trigger: RTL and testbench

- Timing/trigger stage directly downstream of the execution-unit time/event queue.
- Runs the relative timing counter that the queue compares against its head timing point, and drives the queue's trigger enable.
- Takes the per-event valid/data the queue releases at each timing point and stretches each into a fixed-length codeword pulse on an output channel for the analog front-end.
- Provides start/stop control, stall detection and a timing-point count.

---
 rtl/qpu_exu_trigger.sv | 147 ++++++++++++++
 tb/tb_qpu_exu_trigger.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_trigger.sv
// Timing/trigger stage behind the execution-unit time/event queue: runs the relative
// time counter, drives the queue trigger enable and stretches released events into pulses.
module qpu_exu_trigger #(
  parameter int TIME_W        = 16,
  parameter int EVENT_NUM     = 4,
  parameter int EV_W          = 8,
  parameter int PULSE_LEN     = 4,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      clr_err_i,
  output logic                      trigger_o,
  input  logic                      clk_ena_i,
  input  logic                      tp_pop_i,
  output logic [TIME_W-1:0]         time_o,
  input  logic [EVENT_NUM-1:0]      evq_valid_i,
  input  logic [EVENT_NUM*EV_W-1:0] evq_data_i,
  output logic [EVENT_NUM-1:0]      ch_valid_o,
  output logic [EVENT_NUM*EV_W-1:0] ch_data_o,
  output logic                      busy_o,
  output logic                      stall_err_o,
  output logic [15:0]               tp_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [TIME_W-1:0] TIME_MAX = '1;
  localparam logic [15:0]       STALL_TO = 16'(STALL_TIMEOUT);
  localparam logic [7:0]        PLEN     = 8'(PULSE_LEN);

  state_t                           state_q, state_d;
  logic [TIME_W-1:0]                time_q, time_d;
  logic [15:0]                      tp_q, tp_d;
  logic [15:0]                      stall_q, stall_d;
  logic                             err_q, err_set;
  logic [EVENT_NUM-1:0][7:0]        pcnt_q;
  logic [EVENT_NUM-1:0][EV_W-1:0]   data_q;
  logic                             active;
  logic                             pulses_idle;

  assign active      = (state_q == S_RUN) || (state_q == S_STALL);
  assign pulses_idle = (pcnt_q == '0);

  // Queue side has no backpressure: clk_ena_i/tp_pop_i/evq_valid_i are single-cycle
  // qualifiers sampled every clock; priority within RUN/STALL is stop > pop > clk_ena.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tp_d    = tp_q;
    stall_d = stall_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          time_d  = '0;
          tp_d    = '0;
          stall_d = '0;
        end
      end
      S_RUN, S_STALL: begin
        if (stop_i) begin
          state_d = S_DRAIN;
        end else if (tp_pop_i) begin
          state_d = S_RUN;
          time_d  = '0;
          tp_d    = (tp_q == 16'hFFFF) ? tp_q : tp_q + 16'd1;
          stall_d = '0;
        end else if (clk_ena_i) begin
          state_d = S_RUN;
          time_d  = (time_q == TIME_MAX) ? time_q : time_q + TIME_W'(1);
          stall_d = '0;
        end else begin
          // Counter parks at the timeout so the error keeps re-asserting while stalled.
          state_d = S_STALL;
          if (state_q == S_RUN)
            stall_d = 16'd1;
          else
            stall_d = (stall_q == STALL_TO) ? stall_q : stall_q + 16'd1;
          err_set = (stall_d == STALL_TO);
        end
      end
      S_DRAIN: begin
        if (pulses_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      time_q  <= '0;
      tp_q    <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      tp_q    <= tp_d;
      stall_q <= stall_d;
      if (err_set)
        err_q <= 1'b1;
      else if (clr_err_i)
        err_q <= 1'b0;
    end
  end

  // Per-channel pulse stretchers; a capture during an active pulse simply reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      data_q <= '0;
    end else begin
      for (int l = 0; l < EVENT_NUM; l++) begin
        if (active && evq_valid_i[l]) begin
          pcnt_q[l] <= PLEN;
          data_q[l] <= evq_data_i[l*EV_W +: EV_W];
        end else if (pcnt_q[l] != 8'd0) begin
          pcnt_q[l] <= pcnt_q[l] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    ch_valid_o = '0;
    for (int l = 0; l < EVENT_NUM; l++)
      ch_valid_o[l] = (pcnt_q[l] != 8'd0);
  end

  assign ch_data_o   = data_q;
  assign trigger_o   = active;
  assign time_o      = time_q;
  assign busy_o      = (state_q != S_IDLE);
  assign stall_err_o = err_q;
  assign tp_count_o  = tp_q;

endmodule

// File: tb/tb_qpu_exu_trigger.sv
// Bench for qpu_exu_trigger: directed timing/stall/pulse/drain scenarios with literal
// expectations, then random traffic against a behavioural model via an expected queue.
module tb_qpu_exu_trigger;

  localparam int TIME_W = 4;
  localparam int NCH    = 4;
  localparam int EV_W   = 8;
  localparam int PL     = 4;
  localparam int TO     = 8;
  localparam int TMAX   = 15;
  localparam int W      = 1 + TIME_W + NCH + NCH*EV_W + 1 + 1 + 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_i, stop_i, clr_err_i, clk_ena_i, tp_pop_i;
  logic [NCH-1:0]     evq_valid_i;
  logic [NCH*EV_W-1:0] evq_data_i;
  logic               trigger_o, busy_o, stall_err_o;
  logic [TIME_W-1:0]  time_o;
  logic [NCH-1:0]     ch_valid_o;
  logic [NCH*EV_W-1:0] ch_data_o;
  logic [15:0]        tp_count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];

  // behavioural model
  bit             m_run, m_drain, m_err;
  int             m_time, m_tp, m_stall;
  int             m_pulse[NCH];
  logic [EV_W-1:0] m_data[NCH];

  qpu_exu_trigger #(
    .TIME_W(TIME_W), .EVENT_NUM(NCH), .EV_W(EV_W),
    .PULSE_LEN(PL), .STALL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .stop_i(stop_i), .clr_err_i(clr_err_i),
    .trigger_o(trigger_o), .clk_ena_i(clk_ena_i), .tp_pop_i(tp_pop_i),
    .time_o(time_o), .evq_valid_i(evq_valid_i), .evq_data_i(evq_data_i),
    .ch_valid_o(ch_valid_o), .ch_data_o(ch_data_o), .busy_o(busy_o),
    .stall_err_o(stall_err_o), .tp_count_o(tp_count_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_drain = 0; m_err = 0;
    m_time = 0; m_tp = 0; m_stall = 0;
    for (int l = 0; l < NCH; l++) begin
      m_pulse[l] = 0;
      m_data[l]  = '0;
    end
  endtask

  // One clock edge of the model, using the inputs the DUT samples at that edge.
  task automatic model_step();
    bit was_run, was_drain, quiet, set_err;
    if (!rst_n) begin
      model_reset();
      return;
    end
    was_run   = m_run;
    was_drain = m_drain;
    quiet     = 1;
    set_err   = 0;
    for (int l = 0; l < NCH; l++) if (m_pulse[l] != 0) quiet = 0;
    for (int l = 0; l < NCH; l++) begin
      if (was_run && evq_valid_i[l]) begin
        m_pulse[l] = PL;
        m_data[l]  = evq_data_i[l*EV_W +: EV_W];
      end else if (m_pulse[l] > 0) begin
        m_pulse[l] = m_pulse[l] - 1;
      end
    end
    if (!was_run && !was_drain) begin
      if (start_i) begin
        m_run = 1; m_time = 0; m_tp = 0; m_stall = 0;
      end
    end else if (was_run) begin
      if (stop_i) begin
        m_run = 0; m_drain = 1;
      end else if (tp_pop_i) begin
        m_time = 0;
        m_tp = (m_tp < 65535) ? m_tp + 1 : 65535;
        m_stall = 0;
      end else if (clk_ena_i) begin
        m_time = (m_time < TMAX) ? m_time + 1 : TMAX;
        m_stall = 0;
      end else begin
        m_stall = (m_stall < TO) ? m_stall + 1 : TO;
        if (m_stall == TO) set_err = 1;
      end
    end else if (quiet) begin
      m_drain = 0;
    end
    if (set_err) m_err = 1;
    else if (clr_err_i) m_err = 0;
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [NCH*EV_W-1:0] d;
    for (int l = 0; l < NCH; l++) d[l*EV_W +: EV_W] = m_data[l];
    pack_exp = {m_run, 4'(m_time),
                {m_pulse[3] != 0, m_pulse[2] != 0, m_pulse[1] != 0, m_pulse[0] != 0},
                d, (m_run || m_drain), m_err, 16'(m_tp)};
  endfunction

  // driver: advance one clock, update the model, queue the expected outputs
  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back(pack_exp());
    #1;
  endtask

  task automatic clear_inputs();
    start_i = 0; stop_i = 0; clr_err_i = 0; clk_ena_i = 0; tp_pop_i = 0;
    evq_valid_i = '0; evq_data_i = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {trigger_o, time_o, ch_valid_o, ch_data_o, busy_o, stall_err_o, tp_count_o};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL model_cmp act=%h exp=%h at %0t", a, e, $time);
      end
    end
  end

  initial begin
    bit stall_mode;
    rst_n = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trigger", 32'(trigger_o), 0);
    chk("rst_time", 32'(time_o), 0);
    chk("rst_valid", 32'(ch_valid_o), 0);
    chk("rst_data", ch_data_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_tp", 32'(tp_count_o), 0);
    rst_n = 1;

    // start and count
    start_i = 1; tick(); start_i = 0; clk_ena_i = 1;
    chk("start_trigger", 32'(trigger_o), 1);
    chk("start_time", 32'(time_o), 0);
    chk("start_busy", 32'(busy_o), 1);
    repeat (10) tick();
    chk("time_10", 32'(time_o), 10);

    // timing-point pops
    tp_pop_i = 1; tick(); tp_pop_i = 0;
    chk("pop_time", 32'(time_o), 0);
    chk("pop_count1", 32'(tp_count_o), 1);
    repeat (2) begin
      tick(); tp_pop_i = 1; tick(); tp_pop_i = 0;
    end
    chk("pop_count3", 32'(tp_count_o), 3);
    repeat (2) tick();

    // stall timeout and sticky error
    clk_ena_i = 0;
    repeat (7) tick();
    chk("stall_err_7", 32'(stall_err_o), 0);
    tick();
    chk("stall_err_8", 32'(stall_err_o), 1);
    chk("stall_time", 32'(time_o), 2);
    chk("stall_trigger", 32'(trigger_o), 1);
    clr_err_i = 1; repeat (2) tick();
    chk("clr_in_stall", 32'(stall_err_o), 1);
    clr_err_i = 0; clk_ena_i = 1; tick();
    clr_err_i = 1; tick(); clr_err_i = 0;
    chk("clr_after", 32'(stall_err_o), 0);
    chk("resume_time", 32'(time_o), 4);

    // pulses and retrigger
    evq_valid_i = 4'b0101; evq_data_i = 32'h00C3_00A1; tick(); evq_valid_i = '0;
    chk("pulse_valid", 32'(ch_valid_o), 32'h5);
    chk("pulse_d0", 32'(ch_data_o[7:0]), 32'hA1);
    chk("pulse_d2", 32'(ch_data_o[23:16]), 32'hC3);
    tick();
    evq_valid_i = 4'b0001; evq_data_i = 32'h0000_00B2; tick(); evq_valid_i = '0;
    chk("retrig_valid", 32'(ch_valid_o), 32'h5);
    chk("retrig_d0", 32'(ch_data_o[7:0]), 32'hB2);
    tick();
    chk("retrig_v1", 32'(ch_valid_o), 32'h5);
    tick();
    chk("retrig_v2", 32'(ch_valid_o), 32'h1);
    tick(); tick();
    chk("retrig_end", 32'(ch_valid_o), 32'h0);
    chk("hold_d2", 32'(ch_data_o[23:16]), 32'hC3);

    // stop and drain
    evq_valid_i = 4'b0010; evq_data_i = 32'h0000_5E00; tick(); evq_valid_i = '0;
    tick();
    stop_i = 1; tick(); stop_i = 0;
    chk("drain_trigger", 32'(trigger_o), 0);
    chk("drain_busy", 32'(busy_o), 1);
    evq_valid_i = 4'b0100; evq_data_i = 32'h0077_0000; tick(); evq_valid_i = '0;
    chk("drain_v", 32'(ch_valid_o), 32'h2);
    tick();
    chk("drain_v_end", 32'(ch_valid_o), 32'h0);
    chk("drain_busy2", 32'(busy_o), 1);
    tick();
    chk("idle_busy", 32'(busy_o), 0);
    chk("drain_nocap", 32'(ch_data_o[23:16]), 32'hC3);

    // start and stop together: start wins
    start_i = 1; stop_i = 1; tick(); start_i = 0;
    chk("ss_trigger", 32'(trigger_o), 1);
    tick(); stop_i = 0;
    chk("ss_stop_next", 32'(trigger_o), 0);
    tick();
    chk("ss_idle", 32'(busy_o), 0);

    // time saturation
    start_i = 1; tick(); start_i = 0;
    repeat (20) tick();
    chk("time_sat", 32'(time_o), TMAX);

    // asynchronous reset mid-pulse
    evq_valid_i = 4'b1111; evq_data_i = $urandom; tick(); evq_valid_i = '0;
    tick();
    @(negedge clk); #1;
    rst_n = 0; #1;
    chk("arst_valid", 32'(ch_valid_o), 0);
    chk("arst_data", ch_data_o, 0);
    chk("arst_trigger", 32'(trigger_o), 0);
    chk("arst_time", 32'(time_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    tick();
    rst_n = 1;

    // random traffic
    stall_mode = 0;
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) stall_mode = ~stall_mode;
      start_i   = ($urandom_range(0, 9) == 0);
      stop_i    = ($urandom_range(0, 29) == 0);
      clr_err_i = ($urandom_range(0, 19) == 0);
      tp_pop_i  = ($urandom_range(0, 9) == 0);
      clk_ena_i = stall_mode ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
      for (int l = 0; l < NCH; l++) evq_valid_i[l] = ($urandom_range(0, 3) == 0);
      evq_data_i = $urandom;
      tick();
    end
    clear_inputs();
    tick();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
